// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-wide RAM port arbiter/sequencer for IF fetch and MEM-stage accesses
//
// Shares one byte-wide RAM port between instruction fetch and the MEM stage.
// MEM wins arbitration; a granted transaction always runs to completion.
// Reads assemble little-endian words one byte per cycle, writes split words into bytes.
//
// Ports:
//   clk_in, rst_in        clock (rising edge), synchronous active-high reset
//   if_req_in/if_addr_in  fetch request (always a 4-byte read), held until if_done_out
//   if_done_out           one-cycle fetch-complete pulse
//   if_data_out           fetched word, held until the next IF grant
//   mem_req_in            MEM request, held until mem_done_out
//   mem_we_in             1 = write, 0 = read
//   mem_size_in           00 = 1 byte, 01 = 2 bytes, 1x = 4 bytes
//   mem_addr_in           start byte address
//   mem_wdata_in          write data, byte k = bits [8k+7:8k]
//   mem_done_out          one-cycle MEM-complete pulse
//   mem_rdata_out         zero-extended read data, held until the next MEM grant
//   ram_din_in            RAM read data, valid the cycle after ram_a_out is presented
//   ram_dout_out          RAM write data
//   ram_a_out             RAM byte address
//   ram_wr_out            write strobe, committed at the next edge

module mem_ctrl #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  if_req_in,
    input  logic [ADDR_WIDTH-1:0] if_addr_in,
    output logic                  if_done_out,
    output logic [31:0]           if_data_out,
    input  logic                  mem_req_in,
    input  logic                  mem_we_in,
    input  logic [1:0]            mem_size_in,
    input  logic [ADDR_WIDTH-1:0] mem_addr_in,
    input  logic [31:0]           mem_wdata_in,
    output logic                  mem_done_out,
    output logic [31:0]           mem_rdata_out,
    input  logic [7:0]            ram_din_in,
    output logic [7:0]            ram_dout_out,
    output logic [ADDR_WIDTH-1:0] ram_a_out,
    output logic                  ram_wr_out
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_MEM = 1'b1;

    logic [1:0]            state;
    logic                  owner;
    logic [2:0]            n_bytes;
    logic [ADDR_WIDTH-1:0] base;
    logic [31:0]           wdata;
    logic [2:0]            issue_idx;
    logic [1:0]            cap_idx;
    // Two-stage pipeline of "a read byte was issued": the RAM returns data one
    // cycle after the address, and it is registered into the lane one edge later.
    logic                  issued_d1;
    logic                  issued_d2;

    logic                  grant_mem;
    logic                  grant_if;
    logic                  grant_any;
    logic                  g_we;
    logic [2:0]            g_n;
    logic [ADDR_WIDTH-1:0] g_addr;

    // Arbitration. The edge ending DONE may hand the port to the other
    // requester only; the finishing owner may still show req high on that
    // edge and must not be granted a second time.
    always_comb begin
        grant_mem = 1'b0;
        grant_if  = 1'b0;
        case (state)
            S_IDLE: begin
                if (mem_req_in) begin
                    grant_mem = 1'b1;
                end else if (if_req_in) begin
                    grant_if = 1'b1;
                end
            end
            S_DONE: begin
                if (owner == OWN_IF) begin
                    grant_mem = mem_req_in;
                end else begin
                    grant_if = if_req_in;
                end
            end
            default: begin
                grant_mem = 1'b0;
                grant_if  = 1'b0;
            end
        endcase
    end

    always_comb begin
        grant_any = grant_mem | grant_if;
        g_we      = grant_mem & mem_we_in;
        g_addr    = grant_mem ? mem_addr_in : if_addr_in;
        if (grant_mem) begin
            case (mem_size_in)
                2'b00:   g_n = 3'd1;
                2'b01:   g_n = 3'd2;
                default: g_n = 3'd4;
            endcase
        end else begin
            g_n = 3'd4;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state         <= S_IDLE;
            owner         <= OWN_IF;
            n_bytes       <= 3'd0;
            base          <= '0;
            wdata         <= 32'd0;
            issue_idx     <= 3'd0;
            cap_idx       <= 2'd0;
            issued_d1     <= 1'b0;
            issued_d2     <= 1'b0;
            ram_wr_out    <= 1'b0;
            ram_a_out     <= '0;
            ram_dout_out  <= 8'd0;
            if_done_out   <= 1'b0;
            mem_done_out  <= 1'b0;
            if_data_out   <= 32'd0;
            mem_rdata_out <= 32'd0;
        end else begin
            if_done_out  <= 1'b0;
            mem_done_out <= 1'b0;

            case (state)
                S_IDLE, S_DONE: begin
                    ram_wr_out <= 1'b0;
                    if (grant_any) begin
                        owner     <= grant_mem ? OWN_MEM : OWN_IF;
                        base      <= g_addr;
                        n_bytes   <= g_n;
                        wdata     <= mem_wdata_in;
                        cap_idx   <= 2'd0;
                        // byte 0 goes out on the granting edge itself
                        issue_idx <= 3'd1;
                        issued_d1 <= ~g_we;
                        issued_d2 <= 1'b0;
                        ram_a_out <= g_addr;
                        ram_wr_out <= g_we;
                        if (g_we) begin
                            ram_dout_out <= mem_wdata_in[7:0];
                        end
                        if (grant_mem) begin
                            mem_rdata_out <= 32'd0;
                        end else begin
                            if_data_out <= 32'd0;
                        end
                        state <= g_we ? S_WRITE : S_READ;
                    end else begin
                        state <= S_IDLE;
                    end
                end

                S_READ: begin
                    if (issue_idx < n_bytes) begin
                        ram_a_out <= base + ADDR_WIDTH'(issue_idx);
                        issue_idx <= issue_idx + 3'd1;
                        issued_d1 <= 1'b1;
                    end else begin
                        issued_d1 <= 1'b0;
                    end
                    issued_d2 <= issued_d1;

                    if (issued_d2) begin
                        if (owner == OWN_MEM) begin
                            mem_rdata_out[{cap_idx, 3'b000} +: 8] <= ram_din_in;
                        end else begin
                            if_data_out[{cap_idx, 3'b000} +: 8] <= ram_din_in;
                        end
                        cap_idx <= cap_idx + 2'd1;
                        if ({1'b0, cap_idx} == n_bytes - 3'd1) begin
                            if (owner == OWN_MEM) begin
                                mem_done_out <= 1'b1;
                            end else begin
                                if_done_out <= 1'b1;
                            end
                            state <= S_DONE;
                        end
                    end
                end

                S_WRITE: begin
                    if (issue_idx < n_bytes) begin
                        ram_a_out    <= base + ADDR_WIDTH'(issue_idx);
                        ram_dout_out <= wdata[{issue_idx[1:0], 3'b000} +: 8];
                        ram_wr_out   <= 1'b1;
                        issue_idx    <= issue_idx + 3'd1;
                    end else begin
                        // last byte was committed on this edge
                        ram_wr_out   <= 1'b0;
                        mem_done_out <= 1'b1;
                        state        <= S_DONE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - self-checking bench for mem_ctrl with a byte RAM model and done scoreboard

module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_done;
    logic [31:0] if_data;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [1:0]  mem_size = 2'd0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic [7:0]  ram_din = 8'd0;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          is_mem;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    logic [7:0] ram [0:1023];
    logic       poke_en = 1'b0;
    logic [9:0] poke_addr = 10'd0;
    logic [7:0] poke_data = 8'd0;

    mem_ctrl #(.ADDR_WIDTH(32)) dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .if_req_in     (if_req),
        .if_addr_in    (if_addr),
        .if_done_out   (if_done),
        .if_data_out   (if_data),
        .mem_req_in    (mem_req),
        .mem_we_in     (mem_we),
        .mem_size_in   (mem_size),
        .mem_addr_in   (mem_addr),
        .mem_wdata_in  (mem_wdata),
        .mem_done_out  (mem_done),
        .mem_rdata_out (mem_rdata),
        .ram_din_in    (ram_din),
        .ram_dout_out  (ram_dout),
        .ram_a_out     (ram_a),
        .ram_wr_out    (ram_wr)
    );

    always #5 clk = ~clk;

    // RAM model: 1 KiB mirrored over the address space, registered read data
    always @(posedge clk) begin
        if (poke_en) begin
            ram[poke_addr] <= poke_data;
        end else if (ram_wr) begin
            ram[ram_a[9:0]] <= ram_dout;
        end
        ram_din <= ram[ram_a[9:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (if_done || mem_done) begin
            chk("done_exclusive", {31'b0, if_done & mem_done}, 32'd0);
            chk("sb_nonempty_at_done", {31'b0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("done_owner", {31'b0, mem_done}, {31'b0, mon_e.is_mem});
                chk("done_data", mon_e.is_mem ? mem_rdata : if_data, mon_e.data);
            end
        end
    end

    task automatic poke_word(input logic [9:0] a, input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            poke_en   = 1'b1;
            poke_addr = a + 10'(k);
            poke_data = w[8*k +: 8];
        end
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic do_req(input bit is_mem, input bit we, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_data, input string tag);
        int  n;
        int  cyc;
        int  wr_cycles;
        bit  done;
        n = is_mem ? ((size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4) : 4;
        @(negedge clk);
        if (is_mem) begin
            mem_req = 1'b1; mem_we = we; mem_size = size; mem_addr = addr; mem_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        sb.push_back('{is_mem, we ? 32'd0 : exp_data});
        cyc = 0; wr_cycles = 0; done = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (ram_wr) wr_cycles++;
            if (cyc == 1) chk({tag, "_cleared"}, is_mem ? mem_rdata : if_data, 32'd0);
            if (cyc <= n) begin
                chk({tag, "_addr"}, ram_a, addr + 32'(cyc - 1));
                if (we) chk({tag, "_wbyte"}, {24'b0, ram_dout}, {24'b0, wdata[8*(cyc-1) +: 8]});
            end
            done = is_mem ? mem_done : if_done;
        end
        chk({tag, "_latency"}, 32'(cyc), we ? 32'(n + 1) : 32'(n + 2));
        chk({tag, "_wr_cycles"}, 32'(wr_cycles), we ? 32'(n) : 32'd0);
        if (is_mem) mem_req = 1'b0; else if_req = 1'b0;
        @(negedge clk);
        chk({tag, "_done_width"}, {30'b0, if_done, mem_done}, 32'd0);
        chk({tag, "_data_held"}, is_mem ? mem_rdata : if_data, we ? 32'd0 : exp_data);
        chk({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int mem_cyc;
        int if_cyc;

        // preload RAM while the controller is held in reset
        poke_word(10'h100, 32'h0000_0513);
        poke_word(10'h020, 32'h0000_0080);
        poke_word(10'h3FE, 32'h4433_2211);

        // reset with both requesters active: MEM byte read and IF fetch queued
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd0; mem_addr = 32'h20;
        if_req = 1'b1; if_addr = 32'h100;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_ram_wr", {31'b0, ram_wr}, 32'd0);
            chk("rst_ram_a", ram_a, 32'd0);
            chk("rst_ram_dout", {24'b0, ram_dout}, 32'd0);
            chk("rst_dones", {30'b0, if_done, mem_done}, 32'd0);
            chk("rst_if_data", if_data, 32'd0);
            chk("rst_mem_rdata", mem_rdata, 32'd0);
        end

        // release: MEM must win, IF granted on the edge ending MEM's DONE
        rst = 1'b0;
        sb.push_back('{1'b1, 32'h0000_0080});
        sb.push_back('{1'b0, 32'h0000_0513});
        cyc = 0; mem_cyc = 0; if_cyc = 0;
        while (if_cyc == 0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) chk("contend_first_grant_addr", ram_a, 32'h20);
            if (cyc == 4) chk("contend_if_grant_addr", ram_a, 32'h100);
            if (mem_done) begin
                mem_cyc = cyc;
                mem_req = 1'b0;
            end
            if (if_done) begin
                if_cyc = cyc;
                if_req = 1'b0;
            end
        end
        chk("contend_mem_done_cycle", 32'(mem_cyc), 32'd3);
        chk("contend_if_done_cycle", 32'(if_cyc), 32'd9);
        @(negedge clk);
        chk("contend_sb_drained", 32'(sb.size()), 32'd0);

        // standalone fetch with address stepping and 6-cycle latency
        do_req(1'b0, 1'b0, 2'd2, 32'h100, 32'd0, 32'h0000_0513, "if_fetch");

        // half and byte reads, upper lanes zero
        poke_word(10'h020, 32'h5678_1234);
        do_req(1'b1, 1'b0, 2'd1, 32'h20, 32'd0, 32'h0000_1234, "mem_half");
        do_req(1'b1, 1'b0, 2'd0, 32'h21, 32'd0, 32'h0000_0012, "mem_byte");

        // word write, then RAM contents and IF readback
        do_req(1'b1, 1'b1, 2'd2, 32'h40, 32'hDEAD_BEEF, 32'd0, "mem_write");
        chk("ram40", {24'b0, ram[10'h040]}, 32'h0000_00EF);
        chk("ram41", {24'b0, ram[10'h041]}, 32'h0000_00BE);
        chk("ram42", {24'b0, ram[10'h042]}, 32'h0000_00AD);
        chk("ram43", {24'b0, ram[10'h043]}, 32'h0000_00DE);
        do_req(1'b0, 1'b0, 2'd2, 32'h40, 32'd0, 32'hDEAD_BEEF, "if_readback");

        // address wrap at the top of the address space
        do_req(1'b1, 1'b0, 2'd3, 32'hFFFF_FFFE, 32'd0, 32'h4433_2211, "mem_wrap");

        // reset mid-write: aborts with no done pulse
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd2; mem_addr = 32'h80; mem_wdata = 32'h1122_3344;
        @(negedge clk);
        @(negedge clk);
        chk("abort_wr_active", {31'b0, ram_wr}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ram_wr", {31'b0, ram_wr}, 32'd0);
        chk("abort_ram_a", ram_a, 32'd0);
        chk("abort_dones", {30'b0, if_done, mem_done}, 32'd0);
        mem_req = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_done", {30'b0, if_done, mem_done}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
